adc_serial_responder: RTL

ADC_SERIAL_RESPONDER -- requirements
Module: adc_serial_responder

---
 rtl/adc_serial_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/adc_serial_responder.sv
// Serial ADC target model: answers 16-clock CS_N/SCLK/SADDR frames with 12-bit values
// taken from a writable 8-entry channel table, all logic clocked by clk50m.
module adc_serial_responder #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [2:0] RESET_CHANNEL = 3'd0
) (
    input  logic        clk50m,
    input  logic        sysreset,
    input  logic        ADC_CS_N,
    input  logic        ADC_SCLK,
    input  logic        ADC_SADDR,
    output logic        ADC_SDAT,
    input  logic        ch_wr_en,
    input  logic [2:0]  ch_wr_addr,
    input  logic [11:0] ch_wr_data,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [2:0]  last_channel
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] saddr_sync_r;
    logic                   cs_prev_r;
    logic                   sclk_prev_r;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   saddr_s;
    logic                   cs_fall_s;
    logic                   cs_rise_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;

    logic [11:0]            ch_table_r [0:7];

    state_t                 state_r;
    state_t                 state_n;
    logic [15:0]            shift_r;
    logic [15:0]            shift_n;
    logic [4:0]             rcnt_r;
    logic [4:0]             rcnt_n;
    logic [4:0]             rcnt_inc_s;
    logic [2:0]             cur_addr_r;
    logic [2:0]             cur_addr_n;
    logic [2:0]             next_addr_r;
    logic [2:0]             next_addr_n;
    logic [2:0]             last_channel_r;
    logic [2:0]             last_channel_n;
    logic                   frame_done_r;
    logic                   frame_done_n;
    logic                   frame_abort_r;
    logic                   frame_abort_n;
    logic                   sdat_r;
    logic                   sdat_n;

    // Input synchronizers and previous-value flops for edge detection
    always_ff @(posedge clk50m or posedge sysreset) begin
        if (sysreset) begin
            cs_sync_r    <= {SYNC_STAGES{1'b1}};
            sclk_sync_r  <= {SYNC_STAGES{1'b1}};
            saddr_sync_r <= {SYNC_STAGES{1'b0}};
            cs_prev_r    <= 1'b1;
            sclk_prev_r  <= 1'b1;
        end else begin
            cs_sync_r    <= {cs_sync_r[SYNC_STAGES-2:0], ADC_CS_N};
            sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], ADC_SCLK};
            saddr_sync_r <= {saddr_sync_r[SYNC_STAGES-2:0], ADC_SADDR};
            cs_prev_r    <= cs_s;
            sclk_prev_r  <= sclk_s;
        end
    end

    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign saddr_s     = saddr_sync_r[SYNC_STAGES-1];
    assign cs_fall_s   = cs_prev_r & ~cs_s;
    assign cs_rise_s   = ~cs_prev_r & cs_s;
    assign sclk_rise_s = ~sclk_prev_r & sclk_s;
    assign sclk_fall_s = sclk_prev_r & ~sclk_s;
    assign rcnt_inc_s  = rcnt_r + 5'd1;

    // Channel value table; a same-cycle load reads the pre-write contents
    always_ff @(posedge clk50m or posedge sysreset) begin
        if (sysreset) begin
            for (int i = 0; i < 8; i++) begin
                ch_table_r[i] <= 12'h000;
            end
        end else if (ch_wr_en) begin
            ch_table_r[ch_wr_addr] <= ch_wr_data;
        end else begin
            ch_table_r[ch_wr_addr] <= ch_table_r[ch_wr_addr];
        end
    end

    // Frame state register, including the registered outputs
    always_ff @(posedge clk50m or posedge sysreset) begin
        if (sysreset) begin
            state_r        <= ST_IDLE;
            shift_r        <= 16'h0000;
            rcnt_r         <= 5'd0;
            cur_addr_r     <= RESET_CHANNEL;
            next_addr_r    <= 3'd0;
            last_channel_r <= 3'd0;
            frame_done_r   <= 1'b0;
            frame_abort_r  <= 1'b0;
            sdat_r         <= 1'b0;
        end else begin
            state_r        <= state_n;
            shift_r        <= shift_n;
            rcnt_r         <= rcnt_n;
            cur_addr_r     <= cur_addr_n;
            next_addr_r    <= next_addr_n;
            last_channel_r <= last_channel_n;
            frame_done_r   <= frame_done_n;
            frame_abort_r  <= frame_abort_n;
            sdat_r         <= sdat_n;
        end
    end

    // Next-state logic; CS_N edges win over any SCLK edge in the same cycle
    always_comb begin
        state_n        = state_r;
        shift_n        = shift_r;
        rcnt_n         = rcnt_r;
        cur_addr_n     = cur_addr_r;
        next_addr_n    = next_addr_r;
        last_channel_n = last_channel_r;
        frame_done_n   = 1'b0;
        frame_abort_n  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    shift_n = {4'h0, ch_table_r[cur_addr_r]};
                    rcnt_n  = 5'd0;
                    state_n = ST_ACTIVE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_n = ST_IDLE;
                    if (rcnt_r != 5'd0) begin
                        frame_abort_n = 1'b1;
                    end else begin
                        frame_abort_n = 1'b0;
                    end
                end else if (sclk_rise_s) begin
                    if (rcnt_r < 5'd16) begin
                        rcnt_n = rcnt_inc_s;
                        // Address bits ADD2..ADD0 arrive on rising edges 3..5
                        if ((rcnt_inc_s >= 5'd3) && (rcnt_inc_s <= 5'd5)) begin
                            next_addr_n = {next_addr_r[1:0], saddr_s};
                        end else begin
                            next_addr_n = next_addr_r;
                        end
                    end else begin
                        rcnt_n = rcnt_r;
                    end
                end else if (sclk_fall_s) begin
                    if (rcnt_r == 5'd16) begin
                        last_channel_n = cur_addr_r;
                        cur_addr_n     = next_addr_r;
                        frame_done_n   = 1'b1;
                        shift_n        = {4'h0, ch_table_r[next_addr_r]};
                        rcnt_n         = 5'd0;
                    end else begin
                        shift_n = {shift_r[14:0], 1'b0};
                    end
                end else begin
                    state_n = ST_ACTIVE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (state_n == ST_ACTIVE) begin
            sdat_n = shift_n[15];
        end else begin
            sdat_n = 1'b0;
        end
    end

    assign ADC_SDAT     = sdat_r;
    assign frame_done   = frame_done_r;
    assign frame_abort  = frame_abort_r;
    assign last_channel = last_channel_r;

endmodule
